ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
- REQ-001 Parameter: ADDR_W, default 11, RAM word-address width (2048 words).
- REQ-002 Parameter: DATA_W, default 32, data width; byte-enable width is DATA_W/8.
- REQ-003 clk  in  1  single clock; all state changes on its rising edge.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 mN_address  in  ADDR_W  requester N (N=0,1) word address.
- REQ-006 mN_byteenable  in  DATA_W/8  requester N byte lanes for writes.
- REQ-007 mN_read / mN_write  in  1 each  requester N read / write request.
- REQ-008 mN_writedata  in  DATA_W  requester N write data.
- REQ-009 mN_lock  in  1  requester N holds the grant across consecutive transfers.
- REQ-010 mN_waitrequest  out  1  high = requester N's request is not accepted this cycle.
- REQ-011 mN_readdata  out  DATA_W  read data returned to requester N.
- REQ-012 mN_readdatavalid  out  1  mN_readdata valid this cycle.
- REQ-013 ram_address, ram_byteenable, ram_writedata  out  ADDR_W, DATA_W/8, DATA_W  to RAM port.
- REQ-014 ram_chipselect, ram_write, ram_clken  out  1 each  to RAM port.
- REQ-015 ram_readdata  in  DATA_W  RAM output, valid one cycle after the address is clocked.

Function
- REQ-016 The RAM shall accept at most one transfer per cycle; a transfer is accepted when mN_(read|write)=1 and mN_waitrequest=0.
- REQ-017 The FSM shall have states IDLE, OWN0 and OWN1: OWNn shall be entered on an accepted transfer from Mn with mN_lock=1.
- REQ-018 In OWNn, only Mn shall be granted; the other requester's waitrequest shall stay high.
- REQ-019 The FSM shall leave OWNn for IDLE on the first cycle Mn has mN_lock=0, whether or not Mn has a transfer accepted that cycle.
- REQ-020 In IDLE with a single requester, that requester shall be granted in the same cycle (zero-wait).
- REQ-021 In IDLE with both requesting, the winner shall be selected per REQ-036/REQ-037.
- REQ-022 mN_waitrequest shall be 0 only when requester N is granted; with no request present it shall be 1.
- REQ-023 For a granted transfer, the block shall drive ram_chipselect=1 combinationally in the same cycle, with ram_address, ram_byteenable and ram_writedata from the granted requester.
- REQ-024 For a granted transfer, ram_write shall equal the granted requester's write.
- REQ-025 If read and write are asserted together, the transfer shall be treated as a write and no readdatavalid shall follow.
- REQ-026 With no grant, ram_chipselect=0 and ram_write=0.
- REQ-027 ram_clken shall be 1 at all times except during reset, when it shall be 0.
- REQ-028 Read latency shall be exactly 1 cycle: mN_readdatavalid=1 on the cycle after an accepted read from N, with mN_readdata=ram_readdata.
- REQ-029 A one-bit registered tag shall record which requester issued the read; back-to-back reads from alternating requesters shall each return to the correct requester.
- REQ-030 mN_readdata shall be driven from ram_readdata regardless of valid; only readdatavalid qualifies it.
- REQ-031 A write to an address in cycle t followed by a read of that address in cycle t+1, from either requester, shall return the new data.

Reset
- REQ-032 While reset=1: state=IDLE, all mN_waitrequest=1, all mN_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0, and the round-robin pointer shall favour M0.
- REQ-033 A read accepted in the cycle before reset asserts shall not produce readdatavalid; the read tag shall be cleared.
- REQ-034 Reset asserted while in OWNn shall return the FSM to IDLE and release the lock.
- REQ-035 The first grant shall be possible in the cycle after reset deasserts.

Configuration
- REQ-036 With macro RAM_ARBITER_RR_EN defined: IDLE contention shall grant the requester not granted most recently, and the pointer shall update on every accepted transfer; two requesters streaming continuously shall alternate 1:1.
- REQ-037 With RAM_ARBITER_RR_EN undefined: M0 shall always win IDLE contention (fixed priority), and no pointer register shall be built.

Verification
- REQ-038 M0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 -> the read is zero-wait, and m0_readdatavalid=1 with data 0xDEADBEEF on the cycle after acceptance.
- REQ-039 M0 and M1 both read continuously for 8 cycles -> with RR_EN, grants alternate M0,M1,M0,...; without RR_EN, M1 waits all 8 cycles.
- REQ-040 M1 writes with m1_lock=1 for 3 cycles while M0 requests -> m0_waitrequest=1 throughout; M0 is granted in the cycle after m1_lock falls.
- REQ-041 M1 writes 0x000000AA with byteenable 0x1 to a word holding 0x11223344 -> a subsequent read returns 0x112233AA.
- REQ-042 M0 read accepted, then reset asserted the next cycle -> m0_readdatavalid stays 0, and all waitrequests and ram_clken are at their REQ-032 values.
- REQ-043 M0 read of address A and M1 write of address A are both requested in the same cycle, M0 winning -> M0 returns the old data and a later read returns M1's data.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
// Zero-wait grant from IDLE, lock-based ownership (OWN0/OWN1) and a 1-cycle
// read return path steered by a registered requester tag.
// Optional build macro RAM_ARBITER_RR_EN: round-robin resolution of IDLE
// contention (default build: M0 has fixed priority, no pointer register).
module ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state;
  logic   req0, req1;
  logic   gnt0, gnt1;
  logic   rd0, rd1;
  logic   rd_pend;  // a read was accepted last cycle
  logic   rd_tag;   // which requester issued it (1 = M1)

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef RAM_ARBITER_RR_EN
  logic rr_last;  // 1 = M1 was granted most recently, so M0 is favoured next

  // Round-robin pointer follows every accepted transfer; reset favours M0.
  always_ff @(posedge clk) begin
    if (reset)     rr_last <= 1'b1;
    else if (gnt0) rr_last <= 1'b0;
    else if (gnt1) rr_last <= 1'b1;
  end
`endif

  // Grant selection: owner-only while locked, otherwise zero-wait with
  // contention resolved by the configured policy. Nothing is granted in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (state)
        OWN0: gnt0 = req0;
        OWN1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
`ifdef RAM_ARBITER_RR_EN
            gnt0 = rr_last;
            gnt1 = ~rr_last;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // RAM request mux; a write that comes with a read is treated as a write.
  assign ram_address    = gnt1 ? m1_address    : m0_address;
  assign ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign ram_chipselect = gnt0 | gnt1;
  assign ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign ram_clken      = ~reset;

  assign rd0 = gnt0 & m0_read & ~m0_write;
  assign rd1 = gnt1 & m1_read & ~m1_write;

  // Ownership FSM: lock on an accepted locked transfer, release on lock drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        OWN0:    if (!m0_lock) state <= IDLE;
        OWN1:    if (!m1_lock) state <= IDLE;
        default: begin
          if (gnt0 && m0_lock)      state <= OWN0;
          else if (gnt1 && m1_lock) state <= OWN1;
        end
      endcase
    end
  end

  // Read return tag: one cycle behind acceptance, matching RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= rd0 | rd1;
      rd_tag  <= rd1;
    end
  end

  // Data is broadcast; only the valid strobe is steered. The strobe is also
  // gated by reset so a read accepted just before reset never returns.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_tag & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_tag & ~reset;

endmodule
